// File: rtl/axi_read_arbiter_pkg.sv
// axi_read_arbiter_pkg: shared state encoding and response constants for the
// two-master AXI read arbiter. Revision 1.0
`default_nettype none

package axi_read_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_t;

   localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

`default_nettype wire

// File: rtl/axi_read_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant. On a tie the master that
// was not granted last wins. Revision 1.0
`default_nettype none

module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant
);

   always_comb begin
      grant = 1'b0;
      case (req)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_grant;
         default: grant = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one read-only AXI slave between two masters with a
// single outstanding transaction and round-robin fairness. Revision 1.0
`default_nettype none

module axi_read_arbiter
   import axi_read_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic              clock,
   input  logic              reset,

   input  logic              m0_arvalid,
   input  logic [ADDR_W-1:0] m0_araddr,
   input  logic [ID_W-1:0]   m0_arid,
   output logic              m0_arready,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [1:0]        m0_rresp,
   output logic              m0_rlast,
   output logic [ID_W-1:0]   m0_rid,
   input  logic              m0_rready,

   input  logic              m1_arvalid,
   input  logic [ADDR_W-1:0] m1_araddr,
   input  logic [ID_W-1:0]   m1_arid,
   output logic              m1_arready,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [1:0]        m1_rresp,
   output logic              m1_rlast,
   output logic [ID_W-1:0]   m1_rid,
   input  logic              m1_rready,

   output logic              s_arvalid,
   output logic [ADDR_W-1:0] s_araddr,
   output logic [ID_W-1:0]   s_arid,
   input  logic              s_arready,
   input  logic              s_rvalid,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [1:0]        s_rresp,
   input  logic              s_rlast,
   input  logic [ID_W-1:0]   s_rid,
   output logic              s_rready
);

   arb_state_t r_state;
   logic       r_grant;
   logic       r_last_grant;

   logic       w_grant;
   logic [1:0] w_req;
   logic       w_in_addr;
   logic       w_in_data;
   logic       w_to_m0;
   logic       w_to_m1;

   assign w_req     = {m1_arvalid, m0_arvalid};
   assign w_in_addr = (r_state == ADDR);
   assign w_in_data = (r_state == DATA);
   assign w_to_m0   = w_in_data & ~r_grant;
   assign w_to_m1   = w_in_data &  r_grant;

   rr_arb2 u_rr_arb2 (
      .req        (w_req),
      .last_grant (r_last_grant),
      .grant      (w_grant)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= IDLE;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (|w_req) begin
                  r_grant <= w_grant;
                  r_state <= ADDR;
               end
            end
            ADDR: begin
               if (s_arvalid && s_arready) begin
                  r_last_grant <= r_grant;
                  r_state      <= DATA;
               end
            end
            DATA: begin
               // Only the last beat ends the burst; rready low stalls here.
               if (s_rvalid && s_rready && s_rlast) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Address channel: pass the granted master straight through while in ADDR.
   assign s_arvalid  = w_in_addr & (r_grant ? m1_arvalid : m0_arvalid);
   assign s_araddr   = r_grant ? m1_araddr : m0_araddr;
   assign s_arid     = r_grant ? m1_arid   : m0_arid;
   assign m0_arready = w_in_addr & ~r_grant & s_arready;
   assign m1_arready = w_in_addr &  r_grant & s_arready;

   assign s_rready   = w_in_data & (r_grant ? m1_rready : m0_rready);

   assign m0_rvalid  = w_to_m0 & s_rvalid;
   assign m0_rdata   = w_to_m0 ? s_rdata : '0;
   assign m0_rresp   = w_to_m0 ? s_rresp : RESP_OKAY;
   assign m0_rlast   = w_to_m0 & s_rlast;
   assign m0_rid     = w_to_m0 ? s_rid   : '0;

   assign m1_rvalid  = w_to_m1 & s_rvalid;
   assign m1_rdata   = w_to_m1 ? s_rdata : '0;
   assign m1_rresp   = w_to_m1 ? s_rresp : RESP_OKAY;
   assign m1_rlast   = w_to_m1 & s_rlast;
   assign m1_rid     = w_to_m1 ? s_rid   : '0;

endmodule

`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed self-checking bench for axi_read_arbiter.
// Revision 1.0
`default_nettype none

module tb_axi_read_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int ID_W   = 4;

   logic              clock = 1'b0;
   logic              reset;
   logic              m0_arvalid, m0_arready, m0_rvalid, m0_rlast, m0_rready;
   logic [ADDR_W-1:0] m0_araddr;
   logic [ID_W-1:0]   m0_arid, m0_rid;
   logic [DATA_W-1:0] m0_rdata;
   logic [1:0]        m0_rresp;
   logic              m1_arvalid, m1_arready, m1_rvalid, m1_rlast, m1_rready;
   logic [ADDR_W-1:0] m1_araddr;
   logic [ID_W-1:0]   m1_arid, m1_rid;
   logic [DATA_W-1:0] m1_rdata;
   logic [1:0]        m1_rresp;
   logic              s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
   logic [ADDR_W-1:0] s_araddr;
   logic [ID_W-1:0]   s_arid, s_rid;
   logic [DATA_W-1:0] s_rdata;
   logic [1:0]        s_rresp;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   axi_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
      .clock(clock), .reset(reset),
      .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
      .m0_arready(m0_arready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rid(m0_rid), .m0_rready(m0_rready),
      .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
      .m1_arready(m1_arready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rid(m1_rid), .m1_rready(m1_rready),
      .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arready(s_arready),
      .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rid(s_rid), .s_rready(s_rready)
   );

   // Inputs change just after a rising edge; outputs are checked 1 time unit later.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; m0_arvalid = 1'b1; m0_araddr = 32'h0000_1000; m0_arid = 4'h1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (s_arvalid !== 1'b0) begin bad++; $display("FAIL reset_s_arvalid cyc=%0d got=%b exp=0", i, s_arvalid); end
         total++; if (m0_arready !== 1'b0) begin bad++; $display("FAIL reset_m0_arready cyc=%0d got=%b exp=0", i, m0_arready); end
         total++; if (m0_rvalid !== 1'b0 || s_rready !== 1'b0) begin bad++; $display("FAIL reset_r_outputs cyc=%0d got rvalid=%b s_rready=%b exp=0", i, m0_rvalid, s_rready); end
      end
      reset = 1'b0;
      settle();
      total++; if (s_arvalid !== 1'b0) begin bad++; $display("FAIL post_reset_idle got=%b exp=0", s_arvalid); end
      tick();
      total++; if (s_arvalid !== 1'b1) begin bad++; $display("FAIL first_grant_s_arvalid got=%b exp=1", s_arvalid); end
      total++; if (s_araddr !== 32'h0000_1000) begin bad++; $display("FAIL first_grant_s_araddr got=%h exp=00001000", s_araddr); end
      total++; if (m0_arready !== 1'b1) begin bad++; $display("FAIL first_grant_m0_arready got=%b exp=1", m0_arready); end
      tick();
      m0_arvalid = 1'b0;
      settle();
      total++; if (m0_rvalid !== 1'b1) begin bad++; $display("FAIL first_data_m0_rvalid got=%b exp=1", m0_rvalid); end
      tick();
   endtask

   task automatic test_single();
      m1_arvalid = 1'b1; m1_araddr = 32'h0200_BFFC; m1_arid = 4'h3;
      s_rdata = 32'h0000_0012; s_rid = 4'h3; s_rresp = 2'b00;
      settle();
      total++; if (s_arvalid !== 1'b0) begin bad++; $display("FAIL single_idle_s_arvalid got=%b exp=0", s_arvalid); end
      tick();
      total++; if (s_arvalid !== 1'b1 || s_araddr !== 32'h0200_BFFC || s_arid !== 4'h3) begin bad++; $display("FAIL single_ar got v=%b a=%h id=%h exp v=1 a=0200bffc id=3", s_arvalid, s_araddr, s_arid); end
      total++; if (m1_arready !== 1'b1 || m0_arready !== 1'b0) begin bad++; $display("FAIL single_arready got m1=%b m0=%b exp m1=1 m0=0", m1_arready, m0_arready); end
      tick();
      m1_arvalid = 1'b0;
      settle();
      total++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h12 || m1_rid !== 4'h3) begin bad++; $display("FAIL single_r got v=%b d=%h id=%h exp v=1 d=00000012 id=3", m1_rvalid, m1_rdata, m1_rid); end
      total++; if (m0_rvalid !== 1'b0 || s_rready !== 1'b1 || s_arvalid !== 1'b0) begin bad++; $display("FAIL single_other got m0_rvalid=%b s_rready=%b s_arvalid=%b exp 0,1,0", m0_rvalid, s_rready, s_arvalid); end
      tick();
      total++; if (m1_rvalid !== 1'b0 || s_rready !== 1'b0) begin bad++; $display("FAIL single_back_idle got rvalid=%b s_rready=%b exp 0,0", m1_rvalid, s_rready); end
   endtask

   task automatic test_back_to_back();
      logic [ADDR_W-1:0] exp_addr;
      logic              exp_g;
      m0_arvalid = 1'b1; m0_araddr = 32'h0000_00A0;
      m1_arvalid = 1'b1; m1_araddr = 32'h0000_00B0;
      for (int t = 0; t < 4; t++) begin
         exp_g    = (t % 2 == 1);
         exp_addr = exp_g ? 32'h0000_00B0 : 32'h0000_00A0;
         s_rdata  = 32'h0000_5000 + t;
         tick();
         total++; if (s_araddr !== exp_addr || s_arvalid !== 1'b1) begin bad++; $display("FAIL b2b_order t=%0d got a=%h v=%b exp a=%h v=1", t, s_araddr, s_arvalid, exp_addr); end
         total++; if ((exp_g ? m0_arready : m1_arready) !== 1'b0) begin bad++; $display("FAIL b2b_loser_arready t=%0d got=1 exp=0", t); end
         tick();
         total++; if ((exp_g ? m1_rvalid : m0_rvalid) !== 1'b1 || (exp_g ? m0_rvalid : m1_rvalid) !== 1'b0) begin bad++; $display("FAIL b2b_rvalid t=%0d got m0=%b m1=%b exp winner=%0d", t, m0_rvalid, m1_rvalid, exp_g); end
         tick();
         total++; if (s_arvalid !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap t=%0d got=%b exp=0", t, s_arvalid); end
      end
      m0_arvalid = 1'b0; m1_arvalid = 1'b0;
   endtask

   task automatic test_backpressure();
      m0_arvalid = 1'b1; m0_araddr = 32'h0000_0C00;
      m1_arvalid = 1'b1; m1_araddr = 32'h0000_0D00;
      tick();
      total++; if (s_araddr !== 32'h0000_0C00) begin bad++; $display("FAIL bp_grant got=%h exp=00000c00", s_araddr); end
      tick();
      m0_arvalid = 1'b0; m0_rready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         settle();
         total++; if (s_rready !== 1'b0 || m0_rvalid !== 1'b1) begin bad++; $display("FAIL bp_hold cyc=%0d got s_rready=%b m0_rvalid=%b exp 0,1", i, s_rready, m0_rvalid); end
         total++; if (m1_arready !== 1'b0 || s_arvalid !== 1'b0) begin bad++; $display("FAIL bp_m1_stalled cyc=%0d got arready=%b s_arvalid=%b exp 0,0", i, m1_arready, s_arvalid); end
         tick();
      end
      m0_rready = 1'b1;
      settle();
      total++; if (s_rready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", s_rready); end
      tick();
      total++; if (m0_rvalid !== 1'b0 || s_arvalid !== 1'b0) begin bad++; $display("FAIL bp_done got rvalid=%b s_arvalid=%b exp 0,0", m0_rvalid, s_arvalid); end
      tick();
      total++; if (s_araddr !== 32'h0000_0D00 || m1_arready !== 1'b1) begin bad++; $display("FAIL bp_m1_next got a=%h arready=%b exp a=00000d00 arready=1", s_araddr, m1_arready); end
      tick();
      m1_arvalid = 1'b0;
      tick();
   endtask

   task automatic test_burst();
      m0_arvalid = 1'b1; m0_araddr = 32'h0000_0E00;
      s_rlast = 1'b0;
      tick();
      tick();
      m0_arvalid = 1'b0;
      for (int b = 0; b < 4; b++) begin
         s_rdata = 32'h0000_0100 + b;
         s_rlast = (b == 3);
         settle();
         total++; if (m0_rvalid !== 1'b1 || m0_rdata !== (32'h0000_0100 + b) || m0_rlast !== (b == 3)) begin bad++; $display("FAIL burst_beat b=%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b", b, m0_rvalid, m0_rdata, m0_rlast, 32'h100 + b, (b == 3)); end
         tick();
      end
      total++; if (m0_rvalid !== 1'b0) begin bad++; $display("FAIL burst_end got=%b exp=0", m0_rvalid); end
   endtask

   task automatic test_mid_reset();
      m0_arvalid = 1'b1; m0_araddr = 32'h0000_0F00;
      m1_araddr  = 32'h0000_0F10;
      tick();
      tick();
      m0_arvalid = 1'b0; m0_rready = 1'b0;
      settle();
      total++; if (m0_rvalid !== 1'b1) begin bad++; $display("FAIL mr_in_data got=%b exp=1", m0_rvalid); end
      reset = 1'b1; m1_arvalid = 1'b1;
      tick();
      total++; if ({s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid} !== 6'b0) begin bad++; $display("FAIL mr_outputs got=%b exp=000000", {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}); end
      reset = 1'b0; m0_arvalid = 1'b1; m0_rready = 1'b1;
      tick();
      total++; if (s_araddr !== 32'h0000_0F00 || m0_arready !== 1'b1) begin bad++; $display("FAIL mr_last_grant got a=%h arready=%b exp a=00000f00 arready=1", s_araddr, m0_arready); end
      tick();
      m0_arvalid = 1'b0; m1_arvalid = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1;
      m0_arvalid = 1'b0; m0_araddr = '0; m0_arid = '0; m0_rready = 1'b1;
      m1_arvalid = 1'b0; m1_araddr = '0; m1_arid = '0; m1_rready = 1'b1;
      s_arready = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b1;
      s_rdata = 32'h0000_00AA; s_rresp = 2'b00; s_rid = 4'h1;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_burst();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
